// File: rtl/network_descriptor_dispatch.sv
// network_descriptor_dispatch
//   Accepts one packet descriptor per wr/ready handshake, reads the packet out
//   of the packet-buffer RAM one 128-bit line per cycle, and streams the lines
//   to the TX MAC with sop/eop framing. Once the eop line has gone out, the
//   bufid is handed back to the free-bufid manager and the block reports ready.
//   Descriptors with a length outside 1..2048 are dropped: no RAM reads and no
//   data, only the bufid release.
//
// Parameters
//   RAM_RD_LAT  packet-RAM read latency (o_pkt_rd to iv_pkt_rdata valid)
//   FIFO_DEPTH  output line FIFO depth, must be >= RAM_RD_LAT+2
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   iv_descriptor         [8:0] bufid, [20:9] length in bytes, [56:21] unused
//   i_descriptor_wr       one-cycle descriptor strobe (ignored unless idle)
//   o_descriptor_ready    registered, high while idle
//   ov_pkt_raddr/o_pkt_rd packet RAM read address {bufid, line} and strobe
//   iv_pkt_rdata          packet RAM read data
//   ov_data/o_data_wr     line to the TX MAC and its valid
//   o_sop/o_eop           first/last line markers
//   ov_invalid_bytes      unused trailing bytes of the eop line, 0 otherwise
//   i_tx_ready            MAC can take a line
//   ov_bufid/o_bufid_release  bufid being returned, one-cycle strobe
//
// Optional feature (macro NETWORK_DESCRIPTOR_DISPATCH_STAT_EN)
//   ov_tx_pkt_cnt  packets sent, ov_drop_cnt  descriptors dropped,
//   ov_wr_err_cnt  descriptor strobes ignored while busy. All wrap.

module network_descriptor_dispatch #(
  parameter int RAM_RD_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [56:0]  iv_descriptor,
  input  logic         i_descriptor_wr,
  output logic         o_descriptor_ready,
  output logic [15:0]  ov_pkt_raddr,
  output logic         o_pkt_rd,
  input  logic [127:0] iv_pkt_rdata,
  output logic [127:0] ov_data,
  output logic         o_data_wr,
  output logic         o_sop,
  output logic         o_eop,
  output logic [3:0]   ov_invalid_bytes,
  input  logic         i_tx_ready,
  output logic [8:0]   ov_bufid,
  output logic         o_bufid_release
`ifdef NETWORK_DESCRIPTOR_DISPATCH_STAT_EN
  ,
  output logic [31:0]  ov_tx_pkt_cnt,
  output logic [15:0]  ov_drop_cnt,
  output logic [15:0]  ov_wr_err_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RAM_RD_LAT + 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_RELEASE} state_t;
  state_t state_reg, state_next;

  logic [8:0]  bufid_reg;
  logic [6:0]  line_reg;
  logic [6:0]  last_line_reg;
  logic [3:0]  invalid_reg;

  logic [11:0] desc_len;
  logic [11:0] len_m1;
  logic        len_ok;
  logic        issue;
  logic        push;
  logic        pop;

  // Read-return pipeline: bit [RAM_RD_LAT-1] lines up with valid iv_pkt_rdata.
  logic [RAM_RD_LAT-1:0] pipe_vld_reg, pipe_sop_reg, pipe_eop_reg;

  // FIFO entry: {eop, sop, data}
  logic [129:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] fifo_count_reg, in_flight_reg;
  logic [CW:0]   occupancy;
  logic          unused_bits;

  assign desc_len    = iv_descriptor[20:9];
  assign len_m1      = desc_len - 12'd1;
  assign len_ok      = (desc_len != 12'd0) && (desc_len <= 12'd2048);
  assign unused_bits = ^{iv_descriptor[56:21], len_m1[11]};

  // Reads already issued count against FIFO space so the FIFO can never overflow.
  assign occupancy = {1'b0, fifo_count_reg} + {1'b0, in_flight_reg};
  assign push      = pipe_vld_reg[RAM_RD_LAT-1];
  assign pop       = (fifo_count_reg != '0) && i_tx_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    issue           = 1'b0;
    o_pkt_rd        = 1'b0;
    ov_pkt_raddr    = 16'd0;
    o_bufid_release = 1'b0;
    ov_bufid        = 9'd0;
    case (state_reg)
      ST_IDLE: begin
        if (i_descriptor_wr) state_next = len_ok ? ST_READ : ST_RELEASE;
      end
      ST_READ: begin
        if (occupancy < DEPTH_LIM) begin
          issue        = 1'b1;
          o_pkt_rd     = 1'b1;
          ov_pkt_raddr = {bufid_reg, line_reg};
          if (line_reg == last_line_reg) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The eop line is on the output registers this cycle.
        if (o_data_wr && o_eop) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        o_bufid_release = 1'b1;
        ov_bufid        = bufid_reg;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Descriptor capture, line counter and ready flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bufid_reg          <= '0;
      line_reg           <= '0;
      last_line_reg      <= '0;
      invalid_reg        <= '0;
      o_descriptor_ready <= 1'b1;
    end else begin
      if (state_reg == ST_IDLE && i_descriptor_wr) begin
        bufid_reg          <= iv_descriptor[8:0];
        line_reg           <= '0;
        last_line_reg      <= len_m1[10:4];   // N-1 = (len-1)>>4
        invalid_reg        <= ~len_m1[3:0];   // (-len) mod 16
        o_descriptor_ready <= 1'b0;
      end
      if (issue) line_reg <= line_reg + 7'd1;
      if (state_reg == ST_RELEASE) o_descriptor_ready <= 1'b1;
    end
  end

  // Read-return tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_vld_reg  <= '0;
      pipe_sop_reg  <= '0;
      pipe_eop_reg  <= '0;
      in_flight_reg <= '0;
    end else begin
      for (int i = RAM_RD_LAT - 1; i > 0; i--) begin
        pipe_vld_reg[i] <= pipe_vld_reg[i-1];
        pipe_sop_reg[i] <= pipe_sop_reg[i-1];
        pipe_eop_reg[i] <= pipe_eop_reg[i-1];
      end
      pipe_vld_reg[0] <= issue;
      pipe_sop_reg[0] <= issue && (line_reg == 7'd0);
      pipe_eop_reg[0] <= issue && (line_reg == last_line_reg);
      case ({issue, push})
        2'b10:   in_flight_reg <= in_flight_reg + CW'(1);
        2'b01:   in_flight_reg <= in_flight_reg - CW'(1);
        default: in_flight_reg <= in_flight_reg;
      endcase
    end
  end

  // FIFO storage has no reset; only the pointers and count do.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {pipe_eop_reg[RAM_RD_LAT-1], pipe_sop_reg[RAM_RD_LAT-1], iv_pkt_rdata};
    end
  end

  // FIFO pointers and the output line registers (the FIFO's registered read).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      fifo_count_reg   <= '0;
      ov_data          <= '0;
      o_data_wr        <= 1'b0;
      o_sop            <= 1'b0;
      o_eop            <= 1'b0;
      ov_invalid_bytes <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == LAST_SLOT) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == LAST_SLOT) ? '0 : rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      if (pop) begin
        o_data_wr                 <= 1'b1;
        {o_eop, o_sop, ov_data}   <= fifo_mem[rd_ptr_reg];
        ov_invalid_bytes          <= fifo_mem[rd_ptr_reg][129] ? invalid_reg : 4'd0;
      end else begin
        // Line stays on the outputs until the MAC is ready again.
        o_data_wr <= 1'b0;
      end
    end
  end

`ifdef NETWORK_DESCRIPTOR_DISPATCH_STAT_EN
  logic drop_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_reg      <= 1'b0;
      ov_tx_pkt_cnt <= '0;
      ov_drop_cnt   <= '0;
      ov_wr_err_cnt <= '0;
    end else begin
      if (i_descriptor_wr) begin
        if (state_reg == ST_IDLE) drop_reg <= !len_ok;
        else                      ov_wr_err_cnt <= ov_wr_err_cnt + 16'd1;
      end
      if (state_reg == ST_RELEASE) begin
        if (drop_reg) ov_drop_cnt   <= ov_drop_cnt + 16'd1;
        else          ov_tx_pkt_cnt <= ov_tx_pkt_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_network_descriptor_dispatch.sv
// Directed bench for network_descriptor_dispatch: a behavioural packet RAM with
// 2-cycle read latency, expectation queues for read addresses, output lines and
// released bufids, and cycle-position checks on the basic latency.
module tb_network_descriptor_dispatch;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic [56:0]  desc;
  logic         desc_wr;
  logic         desc_ready;
  logic [15:0]  pkt_raddr;
  logic         pkt_rd;
  logic [127:0] pkt_rdata;
  logic [127:0] data;
  logic         data_wr;
  logic         sop;
  logic         eop;
  logic [3:0]   inv_bytes;
  logic         tx_ready;
  logic [8:0]   bufid;
  logic         bufid_rel;
`ifdef NETWORK_DESCRIPTOR_DISPATCH_STAT_EN
  logic [31:0]  tx_pkt_cnt;
  logic [15:0]  drop_cnt;
  logic [15:0]  wr_err_cnt;
`endif

  network_descriptor_dispatch #(.RAM_RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .iv_descriptor      (desc),
    .i_descriptor_wr    (desc_wr),
    .o_descriptor_ready (desc_ready),
    .ov_pkt_raddr       (pkt_raddr),
    .o_pkt_rd           (pkt_rd),
    .iv_pkt_rdata       (pkt_rdata),
    .ov_data            (data),
    .o_data_wr          (data_wr),
    .o_sop              (sop),
    .o_eop              (eop),
    .ov_invalid_bytes   (inv_bytes),
    .i_tx_ready         (tx_ready),
    .ov_bufid           (bufid),
    .o_bufid_release    (bufid_rel)
`ifdef NETWORK_DESCRIPTOR_DISPATCH_STAT_EN
    ,
    .ov_tx_pkt_cnt      (tx_pkt_cnt),
    .ov_drop_cnt        (drop_cnt),
    .ov_wr_err_cnt      (wr_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {a ^ 16'h1357, a ^ 16'h2468, a ^ 16'h9abc, a ^ 16'hdef0,
            ~a, a ^ 16'h0f0f, a ^ 16'hf0f0, a};
  endfunction

  // Packet RAM model: data valid LAT cycles after o_pkt_rd, X otherwise.
  logic [15:0] ram_a1, ram_a2;
  logic        ram_v1 = 1'b0, ram_v2 = 1'b0;
  always @(posedge clk) begin
    ram_v1 <= pkt_rd;
    ram_a1 <= pkt_raddr;
    ram_v2 <= ram_v1;
    ram_a2 <= ram_a1;
  end
  assign pkt_rdata = ram_v2 ? pat(ram_a2) : 'x;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rel_cnt = 0;

  logic [15:0]  exp_addr_q [$];
  logic [133:0] exp_line_q [$];   // {data, sop, eop, invalid}
  logic [8:0]   exp_rel_q  [$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check whatever the DUT produced in it.
  task automatic tick();
    logic [133:0] e;
    @(posedge clk);
    @(negedge clk);
    if (data_wr) begin
      wr_cnt++;
      chk("line_expected", 160'(exp_line_q.size() != 0), 160'd1);
      if (exp_line_q.size() != 0) begin
        e = exp_line_q.pop_front();
        chk("line", 160'({data, sop, eop, inv_bytes}), 160'(e));
      end
    end
    if (pkt_rd) begin
      chk("rd_outstanding", 160'((rd_cnt - wr_cnt) < DEPTH), 160'd1);
      chk("rd_expected", 160'(exp_addr_q.size() != 0), 160'd1);
      if (exp_addr_q.size() != 0) chk("rd_addr", 160'(pkt_raddr), 160'(exp_addr_q.pop_front()));
      rd_cnt++;
    end
    if (bufid_rel) begin
      rel_cnt++;
      chk("rel_expected", 160'(exp_rel_q.size() != 0), 160'd1);
      if (exp_rel_q.size() != 0) chk("rel_bufid", 160'(bufid), 160'(exp_rel_q.pop_front()));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},   160'(desc_ready), 160'd1);
    chk({tag, "_rd"},      160'(pkt_rd),     160'd0);
    chk({tag, "_raddr"},   160'(pkt_raddr),  160'd0);
    chk({tag, "_data_wr"}, 160'(data_wr),    160'd0);
    chk({tag, "_line"},    160'({data, sop, eop, inv_bytes}), 160'd0);
    chk({tag, "_release"}, 160'({bufid_rel, bufid}), 160'd0);
  endtask

  task automatic push_expect(input logic [8:0] b, input int len);
    int n;
    logic [15:0] a;
    logic [3:0]  inv;
    if (len >= 1 && len <= 2048) begin
      n   = (len + 15) / 16;
      inv = 4'((16 - (len % 16)) % 16);
      for (int i = 0; i < n; i++) begin
        a = {b, 7'(i)};
        exp_addr_q.push_back(a);
        exp_line_q.push_back({pat(a), i == 0, i == n - 1, (i == n - 1) ? inv : 4'd0});
      end
    end
    exp_rel_q.push_back(b);
  endtask

  // Send one descriptor and run until its bufid is released.
  task automatic run_pkt(input logic [8:0] b, input int len, input int spur_at, input bit toggle,
                         output int t_rd, output int t_data, output int t_rel);
    int  base_rd, base_wr, base_rel;
    bit  done;
    t_rd = -1; t_data = -1; t_rel = -1;
    base_rd = rd_cnt; base_wr = wr_cnt; base_rel = rel_cnt;
    done = 1'b0;
    push_expect(b, len);
    desc    = {4'($urandom), 32'($urandom), 12'(len), b};
    desc_wr = 1'b1;
    for (int c = 1; c <= 600 && !done; c++) begin
      tick();
      if (c == 1) chk("ready_low_after_wr", 160'(desc_ready), 160'd0);
      if (t_rd < 0 && rd_cnt != base_rd) t_rd = c;
      if (t_data < 0 && wr_cnt != base_wr) t_data = c;
      if (rel_cnt != base_rel) begin
        t_rel = c;
        done  = 1'b1;
        chk("ready_low_at_release", 160'(desc_ready), 160'd0);
      end
      desc_wr = (c == spur_at);
      if (c == spur_at) desc = {36'h0, 12'd16, 9'd30};
      tx_ready = toggle ? ((c >= 20 && c < 30) ? 1'b0 : c[0]) : 1'b1;
    end
    desc_wr  = 1'b0;
    tx_ready = 1'b1;
    chk("release_seen", 160'(done), 160'd1);
    tick();
    chk("ready_after_release", 160'(desc_ready), 160'd1);
    chk("lines_all_seen", 160'(exp_line_q.size()), 160'd0);
    chk("reads_all_seen", 160'(exp_addr_q.size()), 160'd0);
  endtask

  int  t_rd, t_data, t_rel;
  int  base_wr;
  bit  got;

  initial begin
    rst_n    = 1'b0;
    desc     = '0;
    desc_wr  = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("ready_idle", 160'(desc_ready), 160'd1);

    // 4 lines from bufid 5, with the cycle positions of rd, sop and release.
    run_pkt(9'd5, 64, 0, 1'b0, t_rd, t_data, t_rel);
    chk("lat_first_rd", 160'(t_rd), 160'(1));
    chk("lat_sop", 160'(t_data), 160'(5));
    chk("lat_release", 160'(t_rel), 160'(9));

    run_pkt(9'd7, 65, 0, 1'b0, t_rd, t_data, t_rel);
    chk("len65_release", 160'(t_rel), 160'(10));

    run_pkt(9'h1FF, 1, 0, 1'b0, t_rd, t_data, t_rel);
    chk("len1_release", 160'(t_rel), 160'(6));

    // Dropped descriptors: release only.
    run_pkt(9'd20, 0, 0, 1'b0, t_rd, t_data, t_rel);
    chk("len0_no_rd", 160'(t_rd), 160'(-1));
    chk("len0_no_data", 160'(t_data), 160'(-1));
    chk("len0_release", 160'(t_rel), 160'(1));
    run_pkt(9'd21, 2049, 0, 1'b0, t_rd, t_data, t_rel);
    chk("len2049_no_rd", 160'(t_rd), 160'(-1));
    chk("len2049_release", 160'(t_rel), 160'(1));

    // Backpressure: tx_ready toggling plus a 10-cycle stall.
    run_pkt(9'd3, 256, 0, 1'b1, t_rd, t_data, t_rel);

    // Largest packet: 128 lines, line field ends at 127.
    run_pkt(9'hAA, 2048, 0, 1'b0, t_rd, t_data, t_rel);
    chk("len2048_release", 160'(t_rel), 160'(133));

    // Second descriptor strobe while busy is ignored.
    run_pkt(9'd9, 48, 3, 1'b0, t_rd, t_data, t_rel);
    chk("spur_release", 160'(t_rel), 160'(8));

`ifdef NETWORK_DESCRIPTOR_DISPATCH_STAT_EN
    chk("stat_tx", 160'(tx_pkt_cnt), 160'd6);
    chk("stat_drop", 160'(drop_cnt), 160'd2);
    chk("stat_wr_err", 160'(wr_err_cnt), 160'd1);
`endif

    // Reset while line 2 of a 10-line packet is on the outputs.
    push_expect(9'd11, 160);
    base_wr = wr_cnt;
    got     = 1'b0;
    desc    = {36'h0, 12'd160, 9'd11};
    desc_wr = 1'b1;
    for (int c = 1; c <= 100 && !got; c++) begin
      tick();
      desc_wr = 1'b0;
      if (wr_cnt - base_wr >= 3) got = 1'b1;
    end
    chk("mid_line2_reached", 160'(got), 160'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_addr_q.delete();
    exp_line_q.delete();
    exp_rel_q.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("ready_after_mid_reset", 160'(desc_ready), 160'd1);
`ifdef NETWORK_DESCRIPTOR_DISPATCH_STAT_EN
    chk("stat_cleared", 160'({tx_pkt_cnt, drop_cnt, wr_err_cnt}), 160'd0);
`endif
    run_pkt(9'd12, 32, 0, 1'b0, t_rd, t_data, t_rel);
    chk("post_reset_release", 160'(t_rel), 160'(7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
